tuple_job_ctrl: RTL

//  Job sequencer for the zero-sum triplet solver. On start, drives the solver's reset and size,

---
 rtl/tuple_sum_pkg.sv | 29 ++
 rtl/tuple_job_ctrl_if.sv | 28 ++
 rtl/tuple_fifo.sv | 55 +++++
 rtl/tuple_job_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tuple_sum_pkg.sv
// Shared types for the zero-sum triplet solver job sequencer.
package tuple_sum_pkg;

  localparam int unsigned TUPLE_W = 8;

  // One solver result. Packed as {t1, t2, t3}, so t1 occupies the most significant byte.
  typedef struct packed {
    logic [TUPLE_W-1:0] t1;
    logic [TUPLE_W-1:0] t2;
    logic [TUPLE_W-1:0] t3;
  } tuple_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRST = 3'd1,
    ST_RUN  = 3'd2,
    ST_ACK  = 3'd3,
    ST_WLOW = 3'd4,
    ST_DONE = 3'd5
  } job_state_e;

  // True when the three fields add up to zero modulo 2^TUPLE_W.
  function automatic logic tuple_sum_zero(input tuple_t t);
    logic [TUPLE_W-1:0] s;
    s = t.t1 + t.t2 + t.t3;
    return s == '0;
  endfunction

endpackage

// File: rtl/tuple_job_ctrl_if.sv
// Tuple handshake bundle: solver valid/ack in, FWFT tuple stream out.
// The master modport is the job controller; the slave modport is the solver plus consumer side.
interface tuple_job_ctrl_if;
  import tuple_sum_pkg::*;

  logic               solver_valid;
  logic [TUPLE_W-1:0] solver_t1;
  logic [TUPLE_W-1:0] solver_t2;
  logic [TUPLE_W-1:0] solver_t3;
  logic               solver_ack;

  logic               out_valid;
  logic               out_ready;
  logic [TUPLE_W-1:0] out_t1;
  logic [TUPLE_W-1:0] out_t2;
  logic [TUPLE_W-1:0] out_t3;

  modport master (
    input  solver_valid, solver_t1, solver_t2, solver_t3, out_ready,
    output solver_ack, out_valid, out_t1, out_t2, out_t3
  );

  modport slave (
    output solver_valid, solver_t1, solver_t2, solver_t3, out_ready,
    input  solver_ack, out_valid, out_t1, out_t2, out_t3
  );

endinterface

// File: rtl/tuple_fifo.sv
// Synchronous first-word-fall-through tuple FIFO. DEPTH must be a power of two.
module tuple_fifo
  import tuple_sum_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  tuple_t push_data,
  input  logic   pop,
  output tuple_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  tuple_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents are not reset, because only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tuple_job_ctrl.sv
// Job sequencer for one zero-sum triplet solver. It resets and sizes the solver, collects
// acked tuples into a FIFO, ends the job after a quiet window, and reports the tuple count.
// Optional build macro TUPLE_JOB_SUMCHECK_EN: drop tuples whose fields do not sum to zero
// modulo 256, and flag them on a sticky sum_err output.
module tuple_job_ctrl
  import tuple_sum_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned QUIET_CYCLES = 320,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TUPLE_W-1:0] job_size,
  output logic               busy,
  output logic               done,
  output logic [TUPLE_W-1:0] tuple_count,
  output logic               solver_reset,
  output logic [TUPLE_W-1:0] solver_size,
`ifdef TUPLE_JOB_SUMCHECK_EN
  output logic               sum_err,
`endif
  tuple_job_ctrl_if.master   bus
);

  localparam int unsigned RST_W   = $clog2(RST_CYCLES);
  localparam int unsigned QUIET_W = $clog2(QUIET_CYCLES + 1);
  localparam logic [TUPLE_W-1:0] COUNT_MAX = '1;

  job_state_e         state;
  logic [RST_W-1:0]   rst_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  tuple_t             in_tuple;
  tuple_t             head_tuple;
  logic               fifo_full;
  logic               fifo_empty;
  logic               sum_ok;
  logic               push;
  logic               pop;

  assign in_tuple = {bus.solver_t1, bus.solver_t2, bus.solver_t3};

`ifdef TUPLE_JOB_SUMCHECK_EN
  assign sum_ok = tuple_sum_zero(in_tuple);
`else
  assign sum_ok = 1'b1;
`endif

  // Push on the same edge that valid is first seen in RUN; the FSM leaves RUN at that edge.
  assign push = (state == ST_RUN) && bus.solver_valid && sum_ok && !fifo_full;
  assign pop  = !fifo_empty && bus.out_ready;

  tuple_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_tuple),
    .pop       (pop),
    .head      (head_tuple),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_t1    = head_tuple.t1;
  assign bus.out_t2    = head_tuple.t2;
  assign bus.out_t3    = head_tuple.t3;

  // Job FSM with registered control outputs; done and solver_ack default to low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      tuple_count  <= '0;
      solver_reset <= 1'b1;
      solver_size  <= '0;
      bus.solver_ack <= 1'b0;
      rst_cnt      <= '0;
      quiet_cnt    <= '0;
`ifdef TUPLE_JOB_SUMCHECK_EN
      sum_err      <= 1'b0;
`endif
    end else begin
      done           <= 1'b0;
      bus.solver_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          solver_reset <= 1'b1;
          if (start) begin
            solver_size <= job_size;
            tuple_count <= '0;
            busy        <= 1'b1;
            rst_cnt     <= '0;
            state       <= ST_SRST;
`ifdef TUPLE_JOB_SUMCHECK_EN
            sum_err     <= 1'b0;
`endif
          end
        end
        ST_SRST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            solver_reset <= 1'b0;
            quiet_cnt    <= '0;
            state        <= ST_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.solver_valid) begin
            quiet_cnt <= '0;
            if (!sum_ok) begin
`ifdef TUPLE_JOB_SUMCHECK_EN
              sum_err <= 1'b1;
`endif
              bus.solver_ack <= 1'b1;
              state          <= ST_ACK;
            end else if (!fifo_full) begin
              if (tuple_count != COUNT_MAX) tuple_count <= tuple_count + 1'b1;
              bus.solver_ack <= 1'b1;
              state          <= ST_ACK;
            end
          end else if (quiet_cnt == QUIET_W'(QUIET_CYCLES - 1)) begin
            done         <= 1'b1;
            solver_reset <= 1'b1;
            state        <= ST_DONE;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_WLOW;
        end
        ST_WLOW: begin
          // Hold off until the solver drops valid, so a tuple is never taken twice.
          if (!bus.solver_valid) begin
            quiet_cnt <= '0;
            state     <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
